// File: rtl/word_assembly_register.sv
// word_assembly_register: byte-serial word register that assembles, extends
// and disassembles a NBYTES x BYTE_W word one byte per clock. It also tracks
// how many bytes are valid and flags overflow and underflow.
//
// Ports:
//   Clock, Reset          rising-edge clock, synchronous active-high reset
//   E                     operation enable (0: state holds, pulses low)
//   FunSel[2:0]           operation select
//   I[BYTE_W-1:0]         input byte
//   DROut[DATA_W-1:0]     assembled word (registered)
//   Count[CNT_W-1:0]      valid bytes held, 0..NBYTES (registered)
//   Full, Empty           occupancy flags, decoded combinationally from Count
//   ByteOut[BYTE_W-1:0]   last unloaded byte (registered, held)
//   ByteValid, Ovf, Udf   one-cycle pulses: unload done, shift-in dropped a
//                         byte, unload attempted while empty
module word_assembly_register #(
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned NBYTES = 4,
    localparam int unsigned DATA_W = BYTE_W * NBYTES,
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              E,
    input  logic [2:0]        FunSel,
    input  logic [BYTE_W-1:0] I,
    output logic [DATA_W-1:0] DROut,
    output logic [CNT_W-1:0]  Count,
    output logic              Full,
    output logic              Empty,
    output logic [BYTE_W-1:0] ByteOut,
    output logic              ByteValid,
    output logic              Ovf,
    output logic              Udf
);

    localparam int unsigned EXT_W = DATA_W - BYTE_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NBYTES);

    typedef enum logic [2:0] {
        OP_LOAD_SEXT  = 3'b000,
        OP_LOAD_ZEXT  = 3'b001,
        OP_SHIFT_LOW  = 3'b010,
        OP_SHIFT_HIGH = 3'b011,
        OP_CLEAR      = 3'b100,
        OP_HOLD       = 3'b101,
        OP_UNLOAD_LOW = 3'b110,
        OP_UNLOAD_HI  = 3'b111
    } op_e;

    logic [DATA_W-1:0] word_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  cnt_dec;
    logic [BYTE_W-1:0] bout_nxt;
    logic              bvalid_nxt;
    logic              ovf_nxt;
    logic              udf_nxt;

    // Occupancy flags straight from the registered count.
    assign Full  = (Count == CNT_MAX);
    assign Empty = (Count == '0);

    // Saturating increment / guarded decrement of occupancy.
    assign cnt_inc = Full ? Count : Count + CNT_W'(1);
    assign cnt_dec = Count - CNT_W'(1);

    // Next-state decode; defaults hold state and keep pulses low.
    always_comb begin
        word_nxt   = DROut;
        cnt_nxt    = Count;
        bout_nxt   = ByteOut;
        bvalid_nxt = 1'b0;
        ovf_nxt    = 1'b0;
        udf_nxt    = 1'b0;
        if (E) begin
            case (op_e'(FunSel))
                OP_LOAD_SEXT: begin
                    word_nxt = {{EXT_W{I[BYTE_W-1]}}, I};
                    cnt_nxt  = CNT_W'(1);
                end
                OP_LOAD_ZEXT: begin
                    word_nxt = {{EXT_W{1'b0}}, I};
                    cnt_nxt  = CNT_W'(1);
                end
                OP_SHIFT_LOW: begin
                    word_nxt = {DROut[EXT_W-1:0], I};
                    cnt_nxt  = cnt_inc;
                    ovf_nxt  = Full;
                end
                OP_SHIFT_HIGH: begin
                    word_nxt = {I, DROut[DATA_W-1:BYTE_W]};
                    cnt_nxt  = cnt_inc;
                    ovf_nxt  = Full;
                end
                OP_CLEAR: begin
                    word_nxt = '0;
                    cnt_nxt  = '0;
                end
                OP_HOLD: begin
                end
                OP_UNLOAD_LOW: begin
                    if (Empty) begin
                        udf_nxt = 1'b1;
                    end else begin
                        bout_nxt   = DROut[BYTE_W-1:0];
                        word_nxt   = {{BYTE_W{1'b0}}, DROut[DATA_W-1:BYTE_W]};
                        cnt_nxt    = cnt_dec;
                        bvalid_nxt = 1'b1;
                    end
                end
                OP_UNLOAD_HI: begin
                    if (Empty) begin
                        udf_nxt = 1'b1;
                    end else begin
                        bout_nxt   = DROut[DATA_W-1:EXT_W];
                        word_nxt   = {DROut[EXT_W-1:0], {BYTE_W{1'b0}}};
                        cnt_nxt    = cnt_dec;
                        bvalid_nxt = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers; reset wins over any sampled operation.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            DROut     <= '0;
            Count     <= '0;
            ByteOut   <= '0;
            ByteValid <= 1'b0;
            Ovf       <= 1'b0;
            Udf       <= 1'b0;
        end else begin
            DROut     <= word_nxt;
            Count     <= cnt_nxt;
            ByteOut   <= bout_nxt;
            ByteValid <= bvalid_nxt;
            Ovf       <= ovf_nxt;
            Udf       <= udf_nxt;
        end
    end

endmodule

// File: tb/tb_word_assembly_register.sv
// tb_word_assembly_register: drives the default-parameter register with
// directed sequences and random operations. Every cycle it compares the DUT
// against an arithmetic model of the word, and it pins the model with
// hand-computed literals. A second BYTE_W=4/NBYTES=2 instance gets directed
// literal checks.
module tb_word_assembly_register;

    localparam int unsigned BW = 8;
    localparam int unsigned NB = 4;
    localparam int unsigned DW = BW * NB;
    localparam int unsigned CW = $clog2(NB + 1);
    localparam longint BASE = longint'(1) << BW;
    localparam longint MOD  = longint'(1) << DW;
    localparam longint TOPW = MOD / BASE;

    logic          Clock;
    logic          Reset;
    logic          E;
    logic [2:0]    FunSel;
    logic [BW-1:0] I;
    logic [DW-1:0] DROut;
    logic [CW-1:0] Count;
    logic          Full;
    logic          Empty;
    logic [BW-1:0] ByteOut;
    logic          ByteValid;
    logic          Ovf;
    logic          Udf;

    // Small-parameter instance signals.
    logic       s_rst;
    logic       s_e;
    logic [2:0] s_fs;
    logic [3:0] s_i;
    logic [7:0] s_dr;
    logic [1:0] s_cnt;
    logic       s_full;
    logic       s_empty;
    logic [3:0] s_bout;
    logic       s_bv;
    logic       s_ovf;
    logic       s_udf;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    // Reference model state.
    longint m_word;
    longint m_cnt;
    longint m_bout;
    bit     m_bv;
    bit     m_ovf;
    bit     m_udf;

    word_assembly_register #(.BYTE_W(BW), .NBYTES(NB)) dut (
        .Clock(Clock), .Reset(Reset), .E(E), .FunSel(FunSel), .I(I),
        .DROut(DROut), .Count(Count), .Full(Full), .Empty(Empty),
        .ByteOut(ByteOut), .ByteValid(ByteValid), .Ovf(Ovf), .Udf(Udf)
    );

    word_assembly_register #(.BYTE_W(4), .NBYTES(2)) dut_s (
        .Clock(Clock), .Reset(s_rst), .E(s_e), .FunSel(s_fs), .I(s_i),
        .DROut(s_dr), .Count(s_cnt), .Full(s_full), .Empty(s_empty),
        .ByteOut(s_bout), .ByteValid(s_bv), .Ovf(s_ovf), .Udf(s_udf)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: the word as an unsigned integer, bytes as base-2^BW digits.
    always @(posedge Clock) begin
        m_bv  = 0;
        m_ovf = 0;
        m_udf = 0;
        if (Reset) begin
            m_word = 0;
            m_cnt  = 0;
            m_bout = 0;
        end else if (E) begin
            case (FunSel)
                3'd0: begin
                    m_word = (longint'(I) >= BASE / 2) ? MOD - BASE + longint'(I) : longint'(I);
                    m_cnt  = 1;
                end
                3'd1: begin
                    m_word = longint'(I);
                    m_cnt  = 1;
                end
                3'd2, 3'd3: begin
                    m_ovf = (m_cnt == NB);
                    if (FunSel == 3'd2) m_word = (m_word * BASE + longint'(I)) % MOD;
                    else                m_word = m_word / BASE + longint'(I) * TOPW;
                    if (m_cnt < NB) m_cnt = m_cnt + 1;
                end
                3'd4: begin
                    m_word = 0;
                    m_cnt  = 0;
                end
                3'd5: ;
                default: begin
                    if (m_cnt == 0) begin
                        m_udf = 1;
                    end else begin
                        if (FunSel == 3'd6) begin
                            m_bout = m_word % BASE;
                            m_word = m_word / BASE;
                        end else begin
                            m_bout = m_word / TOPW;
                            m_word = (m_word % TOPW) * BASE;
                        end
                        m_cnt = m_cnt - 1;
                        m_bv  = 1;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge Clock) begin
        if (chk_en) begin
            chk("DROut",     64'(DROut),     64'(m_word));
            chk("Count",     64'(Count),     64'(m_cnt));
            chk("Full",      64'(Full),      64'(m_cnt == NB));
            chk("Empty",     64'(Empty),     64'(m_cnt == 0));
            chk("ByteOut",   64'(ByteOut),   64'(m_bout));
            chk("ByteValid", 64'(ByteValid), 64'(m_bv));
            chk("Ovf",       64'(Ovf),       64'(m_ovf));
            chk("Udf",       64'(Udf),       64'(m_udf));
        end
    end

    task automatic step(input logic rst, input logic e, input logic [2:0] fs, input logic [BW-1:0] d);
        Reset  = rst;
        E      = e;
        FunSel = fs;
        I      = d;
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic sstep(input logic rst, input logic e, input logic [2:0] fs, input logic [3:0] d);
        s_rst = rst;
        s_e   = e;
        s_fs  = fs;
        s_i   = d;
        @(posedge Clock);
        @(negedge Clock);
    endtask

    logic [7:0] seq [4];
    logic [7:0] ul  [4];
    logic [7:0] uh  [4];

    initial begin
        Reset = 1'b1; E = 1'b0; FunSel = 3'd0; I = '0;
        s_rst = 1'b1; s_e = 1'b0; s_fs = 3'd0; s_i = '0;
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        ul[0]  = 8'h44; ul[1]  = 8'h33; ul[2]  = 8'h22; ul[3]  = 8'h11;
        uh[0]  = 8'h11; uh[1]  = 8'h22; uh[2]  = 8'h33; uh[3]  = 8'h44;

        step(1'b1, 1'b0, 3'd0, 8'h00);
        chk_en = 1;
        chk("lit reset DROut", 64'(DROut), 64'h0);
        chk("lit reset Empty", 64'(Empty), 64'h1);

        step(1'b0, 1'b1, 3'd0, 8'h80);
        chk("lit sext DROut", 64'(DROut), 64'hFFFF_FF80);
        chk("lit sext Count", 64'(Count), 64'h1);
        step(1'b0, 1'b1, 3'd1, 8'h80);
        chk("lit zext DROut", 64'(DROut), 64'h0000_0080);

        step(1'b0, 1'b1, 3'd4, 8'h00);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 3'd2, seq[k]);
        chk("lit shl DROut", 64'(DROut), 64'h1122_3344);
        chk("lit shl Full",  64'(Full),  64'h1);
        chk("lit shl Ovf0",  64'(Ovf),   64'h0);
        step(1'b0, 1'b1, 3'd2, 8'h55);
        chk("lit shl ovf DROut", 64'(DROut), 64'h2233_4455);
        chk("lit shl ovf Ovf",   64'(Ovf),   64'h1);
        step(1'b0, 1'b1, 3'd5, 8'h00);
        chk("lit ovf pulse end", 64'(Ovf), 64'h0);

        step(1'b0, 1'b1, 3'd4, 8'h00);
        step(1'b0, 1'b1, 3'd3, 8'hAA);
        chk("lit shh 1", 64'(DROut), 64'hAA00_0000);
        step(1'b0, 1'b1, 3'd3, 8'hBB);
        chk("lit shh 2", 64'(DROut), 64'hBBAA_0000);
        chk("lit shh Count", 64'(Count), 64'h2);

        // Unload low then unload high from a full word.
        for (int pass = 0; pass < 2; pass++) begin
            step(1'b0, 1'b1, 3'd4, 8'h00);
            for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 3'd2, seq[k]);
            for (int k = 0; k < 4; k++) begin
                step(1'b0, 1'b1, (pass == 0) ? 3'd6 : 3'd7, 8'h00);
                chk("lit unload ByteOut", 64'(ByteOut), 64'((pass == 0) ? ul[k] : uh[k]));
                chk("lit unload Valid", 64'(ByteValid), 64'h1);
            end
            chk("lit unload DROut", 64'(DROut), 64'h0);
            chk("lit unload Empty", 64'(Empty), 64'h1);
            step(1'b0, 1'b1, (pass == 0) ? 3'd6 : 3'd7, 8'h00);
            chk("lit udf Udf", 64'(Udf), 64'h1);
            chk("lit udf ByteOut", 64'(ByteOut), 64'((pass == 0) ? 8'h11 : 8'h44));
            chk("lit udf Valid", 64'(ByteValid), 64'h0);
        end

        step(1'b0, 1'b1, 3'd1, 8'h5A);
        step(1'b0, 1'b0, 3'd4, 8'h00);
        chk("lit E0 DROut", 64'(DROut), 64'h5A);
        chk("lit E0 Count", 64'(Count), 64'h1);
        step(1'b0, 1'b1, 3'd2, 8'h01);
        step(1'b1, 1'b1, 3'd2, 8'hFF);
        chk("lit rst DROut", 64'(DROut), 64'h0);
        chk("lit rst Count", 64'(Count), 64'h0);

        // Random operations checked by the per-cycle compare process.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 88) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)),
                 8'($urandom));
        end

        // Small-parameter instance: BYTE_W=4, NBYTES=2.
        sstep(1'b1, 1'b0, 3'd0, 4'h0);
        chk("small reset DROut", 64'(s_dr), 64'h0);
        sstep(1'b0, 1'b1, 3'd0, 4'h9);
        chk("small sext DROut", 64'(s_dr), 64'hF9);
        chk("small sext Count", 64'(s_cnt), 64'h1);
        sstep(1'b0, 1'b1, 3'd2, 4'h3);
        chk("small shl1 DROut", 64'(s_dr), 64'h93);
        chk("small shl1 Ovf", 64'(s_ovf), 64'h0);
        chk("small shl1 Full", 64'(s_full), 64'h1);
        sstep(1'b0, 1'b1, 3'd2, 4'h3);
        chk("small shl2 DROut", 64'(s_dr), 64'h33);
        chk("small shl2 Ovf", 64'(s_ovf), 64'h1);
        chk("small shl2 Count", 64'(s_cnt), 64'h2);
        sstep(1'b0, 1'b1, 3'd7, 4'h0);
        chk("small unl ByteOut", 64'(s_bout), 64'h3);
        chk("small unl Count", 64'(s_cnt), 64'h1);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/word_assembly_register.md
# word_assembly_register

Parametrised byte-serial data register that assembles, extends and disassembles a multi-byte word one byte per clock. It sits between byte-wide memory/bus paths and the word-wide datapath, replacing the fixed 8-to-32-bit data register with configurable byte width and byte count. It adds occupancy tracking, byte unloading and overflow/underflow flags.

## Interface
- BYTE_W, default 8: width of one byte lane (≥1).
- NBYTES, default 4: byte lanes per word (≥2).
- DATA_W, derived = BYTE_W*NBYTES: word width (localparam, not overridable).
- CNT_W, derived = $clog2(NBYTES+1): occupancy counter width (localparam).
- Clock  in  1  sole clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset; sampled on rising edge of Clock.
- E  in  1  operation enable; when 0, all state holds.
- FunSel  in  3  operation select (see Operation).
- I  in  BYTE_W  input byte.
- DROut  out  DATA_W  assembled word (registered).
- Count  out  CNT_W  valid bytes held, 0..NBYTES (registered).
- Full  out  1  Count==NBYTES (combinational from Count).
- Empty  out  1  Count==0 (combinational from Count).
- ByteOut  out  BYTE_W  last unloaded byte (registered, holds until next unload).
- ByteValid  out  1  one-cycle pulse: ByteOut updated by an unload.
- Ovf  out  1  one-cycle pulse: shift-in while Full discarded a byte.
- Udf  out  1  one-cycle pulse: unload attempted while Empty.

## Operation
- Priority: Reset > E==0 > FunSel decode.
- Reset: DROut=0, Count=0, ByteOut=0, ByteValid=0, Ovf=0, Udf=0.
- E==0: DROut, Count, ByteOut hold; ByteValid, Ovf, Udf are 0.
- FunSel (E==1):
  - 000 load sign-extend: DROut = {replicate(I[BYTE_W-1]), I}; Count=1.
  - 001 load zero-extend: DROut = {0, I}; Count=1.
  - 010 shift-in low: DROut = {DROut[DATA_W-BYTE_W-1:0], I}; Count = Count+1, saturating at NBYTES. If Full beforehand, Ovf=1 (top byte lost).
  - 011 shift-in high: DROut = {I, DROut[DATA_W-1:BYTE_W]}; Count saturating +1; Ovf=1 if Full beforehand.
  - 100 clear: DROut=0, Count=0.
  - 101 hold: no change; all pulses 0.
  - 110 unload low: if !Empty, ByteOut = DROut[BYTE_W-1:0], DROut = {0, DROut[DATA_W-1:BYTE_W]}, Count-1, ByteValid=1. If Empty, no state change, Udf=1.
  - 111 unload high: if !Empty, ByteOut = DROut[DATA_W-1:DATA_W-BYTE_W], DROut = {DROut[DATA_W-BYTE_W-1:0], 0}, Count-1, ByteValid=1. If Empty, no state change, Udf=1.
- Pulses (ByteValid, Ovf, Udf) are 0 in any cycle not caused by their own operation; at most one is 1 in a cycle.
- Count tracks occupancy only; DROut content is not masked by Count (loaded extension bits count as non-valid bytes).
- Count never exceeds NBYTES nor wraps below 0.

## Timing
- All outputs except Full/Empty registered; effect of an operation visible in the cycle after the sampling edge.
- Latency: 1 cycle for every operation; back-to-back operations every cycle, no stalls.
- Pulses high for exactly one cycle following the edge that performed the operation.
- Reset asserted mid-sequence (e.g. partially assembled word) discards everything at that edge; operation sampled on the same edge is ignored.
- Full/Empty follow Count combinationally, with no extra latency.

## Test plan
- Default params; reset, then E=1 FunSel=000 I=0x80 -> DROut=0xFFFFFF80, Count=1; FunSel=001 I=0x80 -> DROut=0x00000080, Count=1.
- Clear, then FunSel=010 with I=0x11,0x22,0x33,0x44 -> DROut=0x11223344, Count=4, Full=1, Ovf=0; next I=0x55 -> DROut=0x22334455, Count=4, Ovf=1 for one cycle.
- Clear, FunSel=011 I=0xAA then 0xBB -> DROut=0xAA000000 then 0xBBAA0000, Count=2.
- From 0x11223344/Count=4: four FunSel=110 -> ByteOut 0x44,0x33,0x22,0x11 each with ByteValid pulse, final DROut=0, Empty=1; fifth unload -> Udf=1, ByteOut stays 0x11, no state change. Repeat with 111 -> ByteOut 0x11,0x22,0x33,0x44.
- E=0 with FunSel=100 -> DROut/Count unchanged, all pulses 0; Reset=1 with E=1 FunSel=010 I=0xFF -> all outputs 0 next cycle.
- BYTE_W=4, NBYTES=2: FunSel=000 I=0x9 -> DROut=0xF9, Count=1; two FunSel=010 I=0x3 -> 0x93 then 0x33 with Ovf=1, Count=2.
